// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: cascaded BCD counter with IDLE/RUN/PAUSE/DONE control.
// Optional lap capture is enabled by defining BCD_STOPWATCH_LAP_EN; without it the
// lap outputs are tied to zero and no lap register exists.
module bcd_stopwatch_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned WRAP       = 1
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_start,
    input  logic                    in_stop,
    input  logic                    in_clear,
    input  logic                    in_lap,
    input  logic                    in_tick,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic [4*NUM_DIGITS-1:0] o_lap,
    output logic                    o_lap_valid,
    output logic [1:0]              o_state,
    output logic                    o_ovf,
    output logic                    o_running
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam int unsigned W = 4 * NUM_DIGITS;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] inc_val;
    logic         all_nines;
    logic         ovf_q, ovf_d;
    logic         running_q;

    // Ripple BCD increment; a carry surviving the top digit means every digit was 9.
    always_comb begin
        logic carry;
        inc_val = count_q;
        carry   = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    // Control FSM and count update; clear beats stop beats start.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        if (in_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!in_stop && in_start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (in_stop) begin
                        state_d = ST_PAUSE;
                    end else if (in_tick) begin
                        if (!all_nines) begin
                            count_d = inc_val;
                        end else if (WRAP != 0) begin
                            count_d = '0;
                            ovf_d   = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!in_stop && in_start) state_d = ST_RUN;
                end
                default: ;  // DONE: only clear leaves
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign o_digits  = count_q;
    assign o_state   = state_q;
    assign o_ovf     = ovf_q;
    assign o_running = running_q;

`ifdef BCD_STOPWATCH_LAP_EN
    logic [W-1:0] lap_q, lap_d;
    logic         lap_valid_q, lap_valid_d;
    logic         lap_take;

    // Lap is lowest priority: blocked by clear, stop, and by start leaving PAUSE.
    always_comb begin
        lap_take    = in_lap && !in_clear && !in_stop &&
                      ((state_q == ST_RUN) || (state_q == ST_PAUSE && !in_start));
        lap_d       = lap_q;
        lap_valid_d = 1'b0;
        if (in_clear) begin
            lap_d = '0;
        end else if (lap_take) begin
            lap_d       = count_q;  // pre-increment value
            lap_valid_d = 1'b1;
        end
    end

    // Lap capture registers.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign o_lap       = lap_q;
    assign o_lap_valid = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap  = in_lap;
    assign o_lap       = '0;
    assign o_lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: one wrapping and one saturating instance
// share stimulus. Lap expectations follow BCD_STOPWATCH_LAP_EN.
module tb_bcd_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, clear, lap, tick;
    logic [15:0] w_digits, w_lap, s_digits, s_lap;
    logic        w_lap_valid, w_ovf, w_running, s_lap_valid, s_ovf, s_running;
    logic [1:0]  w_state, s_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.NUM_DIGITS(4), .WRAP(1)) dut_w (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_stop(stop), .in_clear(clear),
        .in_lap(lap), .in_tick(tick), .o_digits(w_digits), .o_lap(w_lap),
        .o_lap_valid(w_lap_valid), .o_state(w_state), .o_ovf(w_ovf), .o_running(w_running)
    );

    bcd_stopwatch_ctrl #(.NUM_DIGITS(4), .WRAP(0)) dut_s (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_stop(stop), .in_clear(clear),
        .in_lap(lap), .in_tick(tick), .o_digits(s_digits), .o_lap(s_lap),
        .o_lap_valid(s_lap_valid), .o_state(s_state), .o_ovf(s_ovf), .o_running(s_running)
    );

`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LapOn = 1'b1;
`else
    localparam bit LapOn = 1'b0;
`endif

    typedef struct {
        logic        start, stop, clear, lap, tick;
        logic [15:0] digits;
        logic [1:0]  state;
        logic        lap_valid;
        logic [15:0] lap_val;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic c, input logic l,
                         input logic t);
        start = s; stop = p; clear = c; lap = l; tick = t;
    endtask

    task automatic step(input logic s, input logic p, input logic c, input logic l,
                        input logic t);
        drive(s, p, c, l, t);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic restart;
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        // start stop clear lap tick | digits state lap_valid lap
        vecs[0]  = '{0, 0, 0, 0, 1, 16'h0000, 2'b00, 1'b0, 16'h0000};
        vecs[1]  = '{0, 1, 0, 1, 0, 16'h0000, 2'b00, 1'b0, 16'h0000};
        vecs[2]  = '{1, 0, 0, 0, 1, 16'h0000, 2'b01, 1'b0, 16'h0000};
        vecs[3]  = '{0, 0, 0, 0, 1, 16'h0001, 2'b01, 1'b0, 16'h0000};
        vecs[4]  = '{0, 0, 0, 0, 1, 16'h0002, 2'b01, 1'b0, 16'h0000};
        vecs[5]  = '{0, 1, 0, 0, 1, 16'h0002, 2'b10, 1'b0, 16'h0000};
        vecs[6]  = '{0, 0, 0, 0, 1, 16'h0002, 2'b10, 1'b0, 16'h0000};
        vecs[7]  = '{1, 0, 0, 0, 0, 16'h0002, 2'b01, 1'b0, 16'h0000};
        vecs[8]  = '{1, 0, 0, 0, 1, 16'h0003, 2'b01, 1'b0, 16'h0000};
        vecs[9]  = '{0, 0, 0, 1, 1, 16'h0004, 2'b01, LapOn, LapOn ? 16'h0003 : 16'h0000};
        vecs[10] = '{1, 1, 1, 0, 1, 16'h0000, 2'b00, 1'b0, 16'h0000};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("reset_digits", {16'h0, w_digits}, 32'h0);
        chk("reset_state", {30'h0, w_state}, 32'h0);
        chk("reset_running", {31'h0, w_running}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].lap, vecs[i].tick);
            chk($sformatf("vec%0d_digits", i), {16'h0, w_digits}, {16'h0, vecs[i].digits});
            chk($sformatf("vec%0d_state", i), {30'h0, w_state}, {30'h0, vecs[i].state});
            chk($sformatf("vec%0d_running", i), {31'h0, w_running},
                {31'h0, vecs[i].state == 2'b01});
            chk($sformatf("vec%0d_lap_valid", i), {31'h0, w_lap_valid},
                {31'h0, vecs[i].lap_valid});
            chk($sformatf("vec%0d_lap", i), {16'h0, w_lap}, {16'h0, vecs[i].lap_val});
        end

        // Twelve ticks, then the 0099 -> 0100 cascade.
        restart();
        ticks(12);
        chk("cnt12_digits", {16'h0, w_digits}, 32'h0012);
        chk("cnt12_state", {30'h0, w_state}, 32'h1);
        chk("cnt12_running", {31'h0, w_running}, 32'h1);
        ticks(87);
        chk("cnt99_digits", {16'h0, w_digits}, 32'h0099);
        ticks(1);
        chk("cnt100_digits", {16'h0, w_digits}, 32'h0100);
        chk("cnt100_ovf", {31'h0, w_ovf}, 32'h0);

        // Stop wins over a simultaneous tick.
        restart();
        ticks(9);
        chk("cnt9_digits", {16'h0, w_digits}, 32'h0009);
        step(0, 1, 0, 0, 1);
        chk("stop_tick_digits", {16'h0, w_digits}, 32'h0009);
        chk("stop_tick_state", {30'h0, w_state}, 32'h2);

        // Asynchronous reset mid-run, then tick alone must not count.
        restart();
        ticks(321);
        chk("cnt321_digits", {16'h0, w_digits}, 32'h0321);
        rst = 1'b1;
        #1;
        chk("async_rst_digits", {16'h0, w_digits}, 32'h0);
        chk("async_rst_state", {30'h0, w_state}, 32'h0);
        chk("async_rst_running", {31'h0, w_running}, 32'h0);
        chk("async_rst_lap", {15'h0, w_lap_valid, w_lap}, 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 0, 1);
        chk("post_rst_tick_digits", {16'h0, w_digits}, 32'h0);
        chk("post_rst_tick_state", {30'h0, w_state}, 32'h0);

        // Lap with simultaneous tick captures the pre-increment value.
        restart();
        ticks(457);
        step(0, 0, 0, 1, 1);
        chk("lap_digits", {16'h0, w_digits}, 32'h0458);
        chk("lap_value", {16'h0, w_lap}, LapOn ? 32'h0457 : 32'h0);
        chk("lap_valid", {31'h0, w_lap_valid}, {31'h0, LapOn});
        step(0, 0, 0, 0, 0);
        chk("lap_valid_drop", {31'h0, w_lap_valid}, 32'h0);
        chk("lap_hold", {16'h0, w_lap}, LapOn ? 32'h0457 : 32'h0);

        // All-9s: wrap versus saturate.
        restart();
        ticks(9999);
        chk("w_9999", {16'h0, w_digits}, 32'h9999);
        chk("s_9999", {16'h0, s_digits}, 32'h9999);
        ticks(1);
        chk("w_wrap_digits", {16'h0, w_digits}, 32'h0);
        chk("w_wrap_ovf", {31'h0, w_ovf}, 32'h1);
        chk("w_wrap_state", {30'h0, w_state}, 32'h1);
        chk("s_sat_digits", {16'h0, s_digits}, 32'h9999);
        chk("s_sat_state", {30'h0, s_state}, 32'h3);
        chk("s_sat_ovf", {31'h0, s_ovf}, 32'h0);
        chk("s_sat_running", {31'h0, s_running}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("w_ovf_drop", {31'h0, w_ovf}, 32'h0);
        chk("s_done_start_state", {30'h0, s_state}, 32'h3);
        chk("s_done_start_digits", {16'h0, s_digits}, 32'h9999);
        step(0, 0, 1, 0, 0);
        chk("s_done_clear_state", {30'h0, s_state}, 32'h0);
        chk("s_done_clear_digits", {16'h0, s_digits}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
